alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Execute-stage sequencer for the shared ALU.
//  - Accepts one decoded ALU op per cycle over a valid/ready handshake.
//  - Drives the ALU's one-hot 41-bit enable vector and carry_in; the ALU is instantiated inside.
//  - Registers the result toward writeback and owns the PSW flags C/Z/N/V, which feed ADDC/SUBC/DADD.
// PARAMETERS
//  DST_W     3        width of destination register index
//  PSW_RST   4'b0000  PSW reset value, ordered {V,N,Z,C}
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      request valid
//  in_ready     out  1      request accepted when in_valid & in_ready
//  in_op        in   4      0 ADD,1 ADDC,2 SUB,3 SUBC,4 DADD,5 XOR,6 AND,7 OR,8 BIT,9 BIC,10 BIS,11-15 illegal
//  in_a,in_b    in   16     operands (a = dst value, b = src/const)
//  in_dst       in   DST_W  destination register index
//  out_valid    out  1      result valid
//  out_ready    in   1      writeback consumes result when out_valid & out_ready
//  out_result   out  16     registered ALU result
//  out_dst      out  DST_W  registered destination index
//  out_wb       out  1      1 = write out_result to out_dst (0 for BIT and illegal ops)
//  out_err      out  1      1 = illegal opcode
//  psw_c,psw_z,psw_n,psw_v  out 1 each  current flags
//  psw_wr_en    in   1      software PSW load
//  psw_wr_data  in   4      {V,N,Z,C} load value
// BEHAVIOUR
//  - Reset: out_valid=0, out_result=0, out_dst=0, out_wb=0, out_err=0, {V,N,Z,C}=PSW_RST.
//    Reset mid-operation discards any held result with no writeback.
//  - in_ready = !out_valid | out_ready (single output register, combinational ready).
//  - Enable mapping: op 0-4 -> enable[9..13]; op 5-10 -> enable[15..20]; all other enable bits = 0.
//    enable is driven only while in_valid; otherwise it is all-zero.
//  - ALU carry_in = psw_c (register value before the accepting edge).
//  - Latency 1: op accepted at edge N -> out_valid=1 after edge N with the result.
//    Full throughput when out_ready=1.
//  - Backpressure: out_valid & !out_ready holds all out_* stable and drives in_ready=0.
//  - Flags update on the accepting edge, so back-to-back ADDC/SUBC chain correctly with no bubble.
//    Let r = ALU result.
//    - Z = (r==0), N = r[15] for every legal op.
//    - ADD/ADDC: C = bit16 of {0,a}+{0,b}+cin (cin = 0 for ADD); V = (a[15]==b[15]) & (r[15]!=a[15]).
//    - SUB/SUBC: computed as a + ~b + cin (cin = 1 for SUB); C = carry-out (1 = no borrow);
//      V = (a[15]!=b[15]) & (r[15]!=a[15]).
//    - DADD: C = decimal carry out of digit 3 of the 4-digit BCD add a+b+cin; V unchanged.
//    - XOR/AND/OR/BIT/BIC/BIS: Z,N updated; C,V unchanged.
//    - Illegal op: accepted, out_err=1, out_wb=0, out_result=0; PSW unchanged.
//  - psw_wr_en and an accept on the same edge: psw_wr_data wins for all four flags.
//  - No internal FSM beyond the output-valid bit: states EMPTY (out_valid=0) / FULL (out_valid=1).
//    - EMPTY -> FULL on accept.
//    - FULL -> EMPTY on out_ready without a new accept.
//    - FULL -> FULL on simultaneous consume + accept (register reloads).
// TESTING
//  - Reset, then ADD a=FFFF b=0001 -> out_result=0000, out_wb=1, C=1 Z=1 N=0 V=0 one cycle after accept.
//  - Back-to-back ADD 0001+FFFF then ADDC 0001+0000 -> second result 0002 (carry chained); final C=0.
//  - SUB a=8000 b=0001 -> 7FFF, C=1, V=1, N=0; SUB 0000-0001 -> FFFF, C=0, N=1.
//  - DADD 0999+0001 cin=0 -> 1000, C=0; DADD 9999+0001 cin=0 -> 0000, C=1, Z=1.
//  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, PSW changes only once;
//    release -> next op accepted the same cycle.
//  - BIT a=00F0 b=000F -> out_wb=0, Z=1; op=12 -> out_err=1, PSW unchanged;
//    psw_wr_en=1 (data=4'b1010) with ADD accept -> PSW=1010; rst while FULL -> out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the shared 16-bit ALU: one-op-per-cycle handshake,
// one-hot ALU enable generation, registered result toward writeback and PSW flag ownership.

module alu_exec_alu (
    input  logic [40:0] en_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] result_o,
    output logic        c_o,
    output logic        v_o
);
    logic        sub_op;
    logic        cin_eff;
    logic [15:0] b_op;
    logic [16:0] add_s;
    logic        add_v;
    logic [4:0]  dc;
    logic [15:0] dadd_r;
    logic        unsupported;

    // SUB/SUBC reuse the adder as a + ~b + cin; ADD forces cin=0, SUB forces cin=1.
    assign sub_op  = en_i[11] | en_i[12];
    assign cin_eff = en_i[9] ? 1'b0 : (en_i[11] ? 1'b1 : cin_i);
    assign b_op    = sub_op ? ~b_i : b_i;
    assign add_s   = {1'b0, a_i} + {1'b0, b_op} + {16'b0, cin_eff};
    assign add_v   = (a_i[15] == b_op[15]) & (add_s[15] != a_i[15]);

    // Four-digit BCD ripple: each digit adds 6 when its binary sum exceeds 9.
    assign dc[0] = cin_i;
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
        logic [4:0] dsum;
        assign dsum              = {1'b0, a_i[4*gi +: 4]} + {1'b0, b_i[4*gi +: 4]} + {4'b0, dc[gi]};
        assign dc[gi+1]          = (dsum > 5'd9);
        assign dadd_r[4*gi +: 4] = dc[gi+1] ? (dsum[3:0] + 4'd6) : dsum[3:0];
    end

    assign unsupported = |{en_i[40:21], en_i[14], en_i[8:0]};

    always_comb begin
        result_o = '0;
        c_o      = add_s[16];
        v_o      = add_v;
        if (|en_i[12:9]) result_o = add_s[15:0];
        if (en_i[13]) begin
            result_o = dadd_r;
            c_o      = dc[4];
        end
        if (en_i[15]) result_o = a_i ^ b_i;
        if (en_i[16]) result_o = a_i & b_i;
        if (en_i[17]) result_o = a_i | b_i;
        if (en_i[18]) result_o = a_i & b_i;
        if (en_i[19]) result_o = a_i & ~b_i;
        if (en_i[20]) result_o = a_i | b_i;
        if (unsupported) result_o = '0;
    end
endmodule

module alu_exec_ctrl #(
    parameter int         DST_W   = 3,
    parameter logic [3:0] PSW_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [DST_W-1:0] in_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [DST_W-1:0] out_dst,
    output logic             out_wb,
    output logic             out_err,
    output logic             psw_c,
    output logic             psw_z,
    output logic             psw_n,
    output logic             psw_v,
    input  logic             psw_wr_en,
    input  logic [3:0]       psw_wr_data
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [15:0]      result_q, result_d;
    logic [DST_W-1:0] dst_q, dst_d;
    logic             wb_q, wb_d;
    logic             err_q, err_d;
    logic [3:0]       psw_q, psw_d;   // {V,N,Z,C}

    logic [40:0]      alu_en;
    logic [15:0]      alu_r;
    logic             alu_c;
    logic             alu_v;
    logic             accept;
    logic             op_legal;

    // Ops 0-4 map to enable 9-13, ops 5-10 to enable 15-20.
    for (genvar gi = 0; gi < 11; gi++) begin : g_en
        localparam int IDX = (gi <= 4) ? (9 + gi) : (10 + gi);
        assign alu_en[IDX] = in_valid && (in_op == 4'(gi));
    end
    assign alu_en[8:0]   = '0;
    assign alu_en[14]    = 1'b0;
    assign alu_en[40:21] = '0;

    alu_exec_alu u_alu (
        .en_i     (alu_en),
        .a_i      (in_a),
        .b_i      (in_b),
        .cin_i    (psw_q[0]),
        .result_o (alu_r),
        .c_o      (alu_c),
        .v_o      (alu_v)
    );

    assign op_legal = (in_op <= 4'd10);
    assign in_ready = (state_q == EMPTY) | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        dst_d    = dst_q;
        wb_d     = wb_q;
        err_d    = err_q;
        psw_d    = psw_q;
        if (accept) begin
            state_d  = FULL;
            result_d = op_legal ? alu_r : 16'h0000;
            dst_d    = in_dst;
            wb_d     = op_legal && (in_op != 4'd8);
            err_d    = !op_legal;
            if (op_legal) begin
                psw_d[1] = (alu_r == 16'h0000);
                psw_d[2] = alu_r[15];
                if (in_op <= 4'd3) begin
                    psw_d[0] = alu_c;
                    psw_d[3] = alu_v;
                end else if (in_op == 4'd4) begin
                    psw_d[0] = alu_c;
                end
            end
        end else if (out_ready) begin
            state_d = EMPTY;
        end
        if (psw_wr_en) psw_d = psw_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            result_q <= '0;
            dst_q    <= '0;
            wb_q     <= 1'b0;
            err_q    <= 1'b0;
            psw_q    <= PSW_RST;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            dst_q    <= dst_d;
            wb_q     <= wb_d;
            err_q    <= err_d;
            psw_q    <= psw_d;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_result = result_q;
    assign out_dst    = dst_q;
    assign out_wb     = wb_q;
    assign out_err    = err_q;
    assign psw_c      = psw_q[0];
    assign psw_z      = psw_q[1];
    assign psw_n      = psw_q[2];
    assign psw_v      = psw_q[3];
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed corner cases plus randomized ops under
// random backpressure, checked against an arithmetic reference model.

module tb_alu_exec_ctrl;
    localparam int         DST_W   = 3;
    localparam logic [3:0] PSW_RST = 4'b0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [3:0]       in_op;
    logic [15:0]      in_a, in_b;
    logic [DST_W-1:0] in_dst;
    logic             out_valid, out_ready;
    logic [15:0]      out_result;
    logic [DST_W-1:0] out_dst;
    logic             out_wb, out_err;
    logic             psw_c, psw_z, psw_n, psw_v;
    logic             psw_wr_en;
    logic [3:0]       psw_wr_data;

    alu_exec_ctrl #(.DST_W(DST_W), .PSW_RST(PSW_RST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dst(out_dst), .out_wb(out_wb), .out_err(out_err),
        .psw_c(psw_c), .psw_z(psw_z), .psw_n(psw_n), .psw_v(psw_v),
        .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      r;
        logic [DST_W-1:0] dst;
        logic             wb;
        logic             err;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_psw = PSW_RST;   // {V,N,Z,C}
    int         bp_mode = 0;       // 0 always ready, 1 random, 2 stalled
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] x);
        return int'(x[15:12]) * 1000 + int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference model: integer arithmetic on the architectural meaning of each op.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] pin, output logic [15:0] r, output logic wb,
                                  output logic err, output logic [3:0] pout);
        int s, sr, sa, sb, cin;
        pout = pin; r = '0; wb = 1'b1; err = 1'b0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd0, 4'd1: begin
                cin = (op == 4'd0) ? 0 : int'(pin[0]);
                s = int'(a) + int'(b) + cin;
                sr = sa + sb + cin;
                r = s[15:0];
                pout[0] = (s > 65535);
                pout[3] = (sr > 32767) || (sr < -32768);
            end
            4'd2, 4'd3: begin
                cin = (op == 4'd2) ? 1 : int'(pin[0]);
                s = int'(a) + (65535 - int'(b)) + cin;
                sr = sa - sb - 1 + cin;
                r = s[15:0];
                pout[0] = (s > 65535);
                pout[3] = (sr > 32767) || (sr < -32768);
            end
            4'd4: begin
                s = bcd2int(a) + bcd2int(b) + int'(pin[0]);
                r = int2bcd(s % 10000);
                pout[0] = (s > 9999);
            end
            4'd5:  r = a ^ b;
            4'd6:  r = a & b;
            4'd7:  r = a | b;
            4'd8:  begin r = a & b; wb = 1'b0; end
            4'd9:  r = a & ~b;
            4'd10: r = a | b;
            default: begin err = 1'b1; wb = 1'b0; end
        endcase
        if (!err) begin
            pout[1] = (r == 16'h0000);
            pout[2] = r[15];
        end
    endfunction

    // Call between a rising edge and the following falling edge; returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [DST_W-1:0] dst, input logic pwe = 1'b0, input logic [3:0] pwd = 4'h0);
        logic acc;
        int n;
        exp_t e;
        logic [15:0] er;
        logic ewb, eerr;
        logic [3:0] np;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dst = dst;
        psw_wr_en = pwe; psw_wr_data = pwd;
        acc = 1'b0; n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                model(op, a, b, m_psw, er, ewb, eerr, np);
                e.r = er; e.dst = dst; e.wb = ewb; e.err = eerr;
                q.push_back(e);
                m_psw = np;
            end
            if (psw_wr_en) m_psw = psw_wr_data;
            #1;
            psw_wr_en = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op %0d not accepted within 100 cycles", op);
        end
    endtask

    task automatic check_out(input string name, input logic [15:0] r, input logic wb,
                             input logic err, input logic [3:0] psw);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'(1'b1));
        chk({name, "_result"}, 32'(out_result), 32'(r));
        chk({name, "_wb"}, 32'(out_wb), 32'(wb));
        chk({name, "_err"}, 32'(out_err), 32'(err));
        chk({name, "_psw"}, 32'({psw_v, psw_n, psw_z, psw_c}), 32'(psw));
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every presented result must match the scoreboard head until it is consumed.
    always @(negedge clk) begin
        if (!rst) begin
            chk("psw_track", 32'({psw_v, psw_n, psw_z, psw_c}), 32'(m_psw));
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: result %0h with empty scoreboard", out_result);
                end else begin
                    chk("sb_result", 32'(out_result), 32'(q[0].r));
                    chk("sb_dst", 32'(out_dst), 32'(q[0].dst));
                    chk("sb_wb", 32'(out_wb), 32'(q[0].wb));
                    chk("sb_err", 32'(out_err), 32'(q[0].err));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_dst = '0;
        psw_wr_en = 1'b0; psw_wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_result", 32'(out_result), 32'h0);
        chk("rst_dst", 32'(out_dst), 32'h0);
        chk("rst_wb_err", 32'({out_wb, out_err}), 32'h0);
        chk("rst_psw", 32'({psw_v, psw_n, psw_z, psw_c}), 32'(PSW_RST));
        @(posedge clk);
        #1;

        send(4'd0, 16'hFFFF, 16'h0001, 3'd1);
        check_out("add_wrap", 16'h0000, 1'b1, 1'b0, 4'b0011);
        send(4'd0, 16'h0001, 16'hFFFF, 3'd2);
        send(4'd1, 16'h0001, 16'h0000, 3'd3);
        check_out("addc_chain", 16'h0002, 1'b1, 1'b0, 4'b0000);
        send(4'd2, 16'h8000, 16'h0001, 3'd4);
        check_out("sub_ovf", 16'h7FFF, 1'b1, 1'b0, 4'b1001);
        send(4'd2, 16'h0000, 16'h0001, 3'd5);
        check_out("sub_borrow", 16'hFFFF, 1'b1, 1'b0, 4'b0100);
        send(4'd4, 16'h0999, 16'h0001, 3'd6);
        check_out("dadd_digit", 16'h1000, 1'b1, 1'b0, 4'b0000);
        send(4'd4, 16'h9999, 16'h0001, 3'd7);
        check_out("dadd_wrap", 16'h0000, 1'b1, 1'b0, 4'b0011);

        // Backpressure: held result, blocked request, release accepts on the same cycle.
        bp_mode = 2;
        send(4'd0, 16'h1234, 16'h1111, 3'd1);
        fork
            send(4'd5, 16'hF0F0, 16'h0FF0, 3'd2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'(1'b0));
                end
                bp_mode = 0;
                @(negedge clk);
                chk("release_in_ready", 32'(in_ready), 32'(1'b1));
            end
        join
        check_out("xor_after_stall", 16'hFF00, 1'b1, 1'b0, 4'b0100);

        send(4'd8, 16'h00F0, 16'h000F, 3'd3);
        check_out("bit_nowb", 16'h0000, 1'b0, 1'b0, 4'b0010);
        send(4'd12, 16'h1234, 16'h5678, 3'd4);
        check_out("illegal", 16'h0000, 1'b0, 1'b1, 4'b0010);
        send(4'd0, 16'h0001, 16'h0001, 3'd5, 1'b1, 4'b1010);
        check_out("psw_wr_wins", 16'h0002, 1'b1, 1'b0, 4'b1010);

        // Reset while a result is held.
        bp_mode = 2;
        send(4'd7, 16'hA5A5, 16'h0F0F, 3'd6);
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        m_psw = PSW_RST;
        #1 rst = 1'b0;
        bp_mode = 0;
        @(negedge clk);
        chk("rst_full_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_full_psw", 32'({psw_v, psw_n, psw_z, psw_c}), 32'(PSW_RST));
        @(posedge clk);
        #1;

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 12));
            a = 16'($urandom);
            b = 16'($urandom);
            if (op == 4'd4) begin
                a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            send(op, a, b, DST_W'($urandom), ($urandom_range(0, 19) == 0), 4'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        bp_mode = 0;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
